// File: rtl/card7seg.sv
// Card-code to 7-segment decoder with a registered output and synchronous clear.
// Define CARD7SEG_ACTIVE_LOW_EN for boards whose segments light on 0.
module card7seg (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SW,
    output logic [6:0] HEX0
);

`ifdef CARD7SEG_ACTIVE_LOW_EN
    localparam logic [6:0] POL = 7'b1111111;
`else
    localparam logic [6:0] POL = 7'b0000000;
`endif

    logic [6:0] seg_d;
    logic [6:0] hex_q;

    // Table is active-high {a..g}; POL flips it for the board polarity.
    always_comb begin
        seg_d = 7'b0000000;
        case (SW)
            4'd1:    seg_d = 7'b1110111;
            4'd2:    seg_d = 7'b1101101;
            4'd3:    seg_d = 7'b1111001;
            4'd4:    seg_d = 7'b0110011;
            4'd5:    seg_d = 7'b1011011;
            4'd6:    seg_d = 7'b1011111;
            4'd7:    seg_d = 7'b1110000;
            4'd8:    seg_d = 7'b1111111;
            4'd9:    seg_d = 7'b1111011;
            4'd10:   seg_d = 7'b1111110;
            4'd11:   seg_d = 7'b0111100;
            4'd12:   seg_d = 7'b1110011;
            4'd13:   seg_d = 7'b0110111;
            default: seg_d = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q <= POL;
        end else begin
            hex_q <= seg_d ^ POL;
        end
    end

    assign HEX0 = hex_q;

endmodule

// File: tb/tb_card7seg.sv
// Directed-vector bench for card7seg; expectations follow the
// CARD7SEG_ACTIVE_LOW_EN build setting.
module tb_card7seg;

    logic       clk;
    logic       rst;
    logic [3:0] SW;
    logic [6:0] HEX0;

    int n_chk;
    int n_err;

`ifdef CARD7SEG_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'b1111111;
`else
    localparam logic [6:0] INV = 7'b0000000;
`endif

    logic [6:0] tbl [16];

    card7seg dut (
        .clk  (clk),
        .rst  (rst),
        .SW   (SW),
        .HEX0 (HEX0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got,
                         input logic [6:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] s);
        rst = r;
        SW  = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        tbl[0]  = 7'b0000000;
        tbl[1]  = 7'b1110111;
        tbl[2]  = 7'b1101101;
        tbl[3]  = 7'b1111001;
        tbl[4]  = 7'b0110011;
        tbl[5]  = 7'b1011011;
        tbl[6]  = 7'b1011111;
        tbl[7]  = 7'b1110000;
        tbl[8]  = 7'b1111111;
        tbl[9]  = 7'b1111011;
        tbl[10] = 7'b1111110;
        tbl[11] = 7'b0111100;
        tbl[12] = 7'b1110011;
        tbl[13] = 7'b0110111;
        tbl[14] = 7'b0000000;
        tbl[15] = 7'b0000000;

        rst = 1'b1;
        SW  = 4'd8;
        @(negedge clk);

        step(1'b1, 4'd8);
        check("reset", HEX0, 7'b0000000 ^ INV);
        step(1'b0, 4'd8);
        check("post_reset_8", HEX0, 7'b1111111 ^ INV);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'(i));
            check($sformatf("sweep_%0d", i), HEX0, tbl[i] ^ INV);
        end

        step(1'b0, 4'd2);
        check("lat_2", HEX0, 7'b1101101 ^ INV);
        SW = 4'd5;
        #4;
        check("lat_hold", HEX0, 7'b1101101 ^ INV);
        @(posedge clk);
        #1;
        check("lat_5", HEX0, 7'b1011011 ^ INV);

        step(1'b0, 4'd13);
        check("mid_13", HEX0, 7'b0110111 ^ INV);
        step(1'b1, 4'd13);
        check("mid_rst", HEX0, 7'b0000000 ^ INV);
        step(1'b0, 4'd13);
        check("mid_rel", HEX0, 7'b0110111 ^ INV);

        step(1'b0, 4'd14);
        check("unused_14", HEX0, 7'b0000000 ^ INV);
        step(1'b0, 4'd15);
        check("unused_15", HEX0, 7'b0000000 ^ INV);

        step(1'b0, 4'd1);
        check("ace", HEX0, 7'b1110111 ^ INV);
        step(1'b0, 4'd10);
        check("ten", HEX0, 7'b1111110 ^ INV);
        step(1'b0, 4'd0);
        check("none", HEX0, 7'b0000000 ^ INV);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
